// File: rtl/reprogram_writer.sv
`default_nettype none
// ============================================================================
//  Module   : reprogram_writer
//  Purpose  : Initiator for the traffic-light controller's time-parameter
//             programming port. It replays a 4-entry timing table, or one
//             manually entered parameter taken from a debounced push-button,
//             as framed setup / strobe / gap write transactions.
//  Revision : 1.0  initial release
// ============================================================================
module reprogram_writer #(
  parameter int HOLD_CYCLES = 2,  // cycles reprogram stays high per write
  parameter int GAP_CYCLES  = 2,  // cycles reprogram stays low after a write
  parameter int DB_CYCLES   = 4   // stable cycles needed to accept a button change
) (
  input  logic        clk,
  input  logic        reset,      // asynchronous, active-low
  input  logic        start,
  input  logic [15:0] cfg_vals,
  input  logic        man_btn,
  input  logic [1:0]  man_sel,
  input  logic [3:0]  man_val,
  output logic [1:0]  tp_sel,
  output logic [3:0]  t_val,
  output logic        reprogram,
  output logic        busy,
  output logic        done
);

  // --------------------------------------------------------------------------
  // Local constants
  // --------------------------------------------------------------------------
  localparam int CNT_MAX = (HOLD_CYCLES > GAP_CYCLES) ? HOLD_CYCLES : GAP_CYCLES;
  localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
  localparam int DB_W    = (DB_CYCLES > 1) ? $clog2(DB_CYCLES) : 1;

  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_CYCLES - 1);
  localparam logic [CNT_W-1:0] GAP_LAST  = CNT_W'(GAP_CYCLES - 1);
  localparam logic [DB_W-1:0]  DB_LAST   = DB_W'(DB_CYCLES - 1);
  localparam logic [1:0]       IDX_LAST  = 2'd3;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_SETUP = 3'd1,
    ST_PULSE = 3'd2,
    ST_GAP   = 3'd3,
    ST_DONE  = 3'd4
  } state_t;

  typedef enum logic {
    MODE_SEQ = 1'b0,
    MODE_MAN = 1'b1
  } mode_t;

  // --------------------------------------------------------------------------
  // Button synchronizer and debounce state
  // --------------------------------------------------------------------------
  logic            sync1_q, sync1_d;
  logic            sync2_q, sync2_d;
  logic            db_level_q, db_level_d;
  logic            db_prev_q, db_prev_d;
  logic [DB_W-1:0] db_cnt_q, db_cnt_d;
  logic            man_req;

  // --------------------------------------------------------------------------
  // Write sequencer state
  // --------------------------------------------------------------------------
  state_t           state_q, state_d;
  mode_t            mode_q, mode_d;
  logic [1:0]       idx_q, idx_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [11:0]      snap_q, snap_d;     // table entries 1..3; entry 0 goes out directly
  logic [1:0]       tp_sel_q, tp_sel_d;
  logic [3:0]       t_val_q, t_val_d;
  logic [1:0]       idx_next;
  logic [3:0]       val_next;

  // Synchronize the raw button and filter it: the debounced level only flips
  // after the synchronized input has disagreed with it for DB_CYCLES cycles.
  always_comb begin
    sync1_d    = man_btn;
    sync2_d    = sync1_q;
    db_level_d = db_level_q;
    db_cnt_d   = '0;
    db_prev_d  = db_level_q;
    if (sync2_q != db_level_q) begin
      if (db_cnt_q == DB_LAST) begin
        db_level_d = sync2_q;
      end else begin
        db_cnt_d = db_cnt_q + 1'b1;
      end
    end
  end

  // A manual request is the single cycle in which the debounced level is new and high.
  assign man_req = db_level_q & ~db_prev_q;

  // Button path registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync1_q    <= 1'b0;
      sync2_q    <= 1'b0;
      db_level_q <= 1'b0;
      db_prev_q  <= 1'b0;
      db_cnt_q   <= '0;
    end else begin
      sync1_q    <= sync1_d;
      sync2_q    <= sync2_d;
      db_level_q <= db_level_d;
      db_prev_q  <= db_prev_d;
      db_cnt_q   <= db_cnt_d;
    end
  end

  // Select the value for the table entry that follows the current index.
  always_comb begin
    idx_next = idx_q + 2'd1;
    val_next = snap_q[3:0];
    case (idx_q)
      2'd0:    val_next = snap_q[3:0];
      2'd1:    val_next = snap_q[7:4];
      default: val_next = snap_q[11:8];
    endcase
  end

  // Next-state logic: frame each write as SETUP, HOLD_CYCLES of PULSE and
  // GAP_CYCLES of GAP; the outputs are loaded only on entry to SETUP.
  always_comb begin
    state_d  = state_q;
    mode_d   = mode_q;
    idx_d    = idx_q;
    cnt_d    = cnt_q;
    snap_d   = snap_q;
    tp_sel_d = tp_sel_q;
    t_val_d  = t_val_q;
    case (state_q)
      ST_IDLE: begin
        cnt_d = '0;
        if (start) begin
          // start has priority; a coincident manual request is discarded
          snap_d   = cfg_vals[15:4];
          idx_d    = 2'd0;
          mode_d   = MODE_SEQ;
          tp_sel_d = 2'd0;
          t_val_d  = cfg_vals[3:0];
          state_d  = ST_SETUP;
        end else if (man_req) begin
          mode_d   = MODE_MAN;
          tp_sel_d = man_sel;
          t_val_d  = man_val;
          state_d  = ST_SETUP;
        end
      end
      ST_SETUP: begin
        cnt_d   = '0;
        state_d = ST_PULSE;
      end
      ST_PULSE: begin
        if (cnt_q == HOLD_LAST) begin
          cnt_d   = '0;
          state_d = ST_GAP;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ST_GAP: begin
        if (cnt_q == GAP_LAST) begin
          cnt_d = '0;
          if ((mode_q == MODE_MAN) || (idx_q == IDX_LAST)) begin
            state_d = ST_DONE;
          end else begin
            idx_d    = idx_next;
            tp_sel_d = idx_next;
            t_val_d  = val_next;
            state_d  = ST_SETUP;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Sequencer registers; reset aborts any write in flight immediately.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= ST_IDLE;
      mode_q   <= MODE_SEQ;
      idx_q    <= 2'd0;
      cnt_q    <= '0;
      snap_q   <= '0;
      tp_sel_q <= 2'd0;
      t_val_q  <= 4'd0;
    end else begin
      state_q  <= state_d;
      mode_q   <= mode_d;
      idx_q    <= idx_d;
      cnt_q    <= cnt_d;
      snap_q   <= snap_d;
      tp_sel_q <= tp_sel_d;
      t_val_q  <= t_val_d;
    end
  end

  // Status and strobe decode straight from the state register, so an
  // asynchronous reset removes the strobe in the same instant.
  always_comb begin
    reprogram = (state_q == ST_PULSE);
    busy      = (state_q == ST_SETUP) || (state_q == ST_PULSE) || (state_q == ST_GAP);
    done      = (state_q == ST_DONE);
    tp_sel    = tp_sel_q;
    t_val     = t_val_q;
  end

endmodule
`default_nettype wire

// File: tb/tb_reprogram_writer.sv
`default_nettype none
// ============================================================================
//  Module   : tb_reprogram_writer
//  Purpose  : Self-checking bench for reprogram_writer. Expected writes are
//             queued as stimulus is applied and matched against each strobe.
//  Revision : 1.0  initial release
// ============================================================================
module tb_reprogram_writer;

  localparam int HOLD = 2;

  logic        clk;
  logic        reset;
  logic        start;
  logic [15:0] cfg_vals;
  logic        man_btn;
  logic [1:0]  man_sel;
  logic [3:0]  man_val;
  logic [1:0]  tp_sel;
  logic [3:0]  t_val;
  logic        reprogram;
  logic        busy;
  logic        done;

  int checks;
  int failures;

  logic [5:0] exp_q[$];

  // monitor state
  logic       mon_prev_rp;
  logic       mon_prev_busy;
  logic [5:0] mon_prev_sv;
  logic [5:0] mon_exp;
  int         mon_len;

  reprogram_writer #(
    .HOLD_CYCLES(2),
    .GAP_CYCLES (2),
    .DB_CYCLES  (4)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
    .cfg_vals (cfg_vals),
    .man_btn  (man_btn),
    .man_sel  (man_sel),
    .man_val  (man_val),
    .tp_sel   (tp_sel),
    .t_val    (t_val),
    .reprogram(reprogram),
    .busy     (busy),
    .done     (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Write monitor: every rising strobe is matched against the scoreboard,
  // must follow a setup cycle with identical tp_sel/t_val, and must last HOLD.
  initial begin
    mon_prev_rp   = 1'b0;
    mon_prev_busy = 1'b0;
    mon_prev_sv   = '0;
    mon_len       = 0;
    forever begin
      @(negedge clk);
      if (!reset) begin
        mon_prev_rp   = 1'b0;
        mon_prev_busy = 1'b0;
        mon_prev_sv   = '0;
        mon_len       = 0;
      end else begin
        if (reprogram && !mon_prev_rp) begin
          checks++;
          if (exp_q.size() == 0) begin
            failures++;
            $display("FAIL unexpected_write: got sel=%0d val=%h, required no write", tp_sel, t_val);
          end else begin
            mon_exp = exp_q.pop_front();
            if ({tp_sel, t_val} !== mon_exp) begin
              failures++;
              $display("FAIL write_data: got sel=%0d val=%h, required sel=%0d val=%h",
                       tp_sel, t_val, mon_exp[5:4], mon_exp[3:0]);
            end
          end
          checks++;
          if ((mon_prev_busy !== 1'b1) || (mon_prev_sv !== {tp_sel, t_val})) begin
            failures++;
            $display("FAIL write_setup: got prev busy=%b sv=%h, required busy=1 sv=%h",
                     mon_prev_busy, mon_prev_sv, {tp_sel, t_val});
          end
          mon_len = 1;
        end else if (reprogram) begin
          mon_len++;
        end else if (mon_prev_rp) begin
          checks++;
          if (mon_len != HOLD) begin
            failures++;
            $display("FAIL strobe_width: got %0d, required %0d", mon_len, HOLD);
          end
        end
        mon_prev_rp   = reprogram;
        mon_prev_busy = busy;
        mon_prev_sv   = {tp_sel, t_val};
      end
    end
  end

  task automatic test_reset();
    reset    = 1'b0;
    start    = 1'b0;
    cfg_vals = 16'h0000;
    man_btn  = 1'b0;
    man_sel  = 2'd0;
    man_val  = 4'd0;
    repeat (3) @(negedge clk);
    checks++;
    if ({tp_sel, t_val, reprogram, busy, done} !== 9'd0) begin
      failures++;
      $display("FAIL reset_outputs: got sel=%0d val=%h rp=%b busy=%b done=%b, required all 0",
               tp_sel, t_val, reprogram, busy, done);
    end
    reset = 1'b1;
    repeat (3) @(negedge clk);
    checks++;
    if ({reprogram, busy, done} !== 3'b000) begin
      failures++;
      $display("FAIL idle_after_reset: got rp=%b busy=%b done=%b, required 0 0 0", reprogram, busy, done);
    end
  endtask

  task automatic test_sequence();
    int busy_n;
    int done_n;
    int done_at;
    busy_n  = 0;
    done_n  = 0;
    done_at = 0;
    cfg_vals = 16'h4A37;
    exp_q.push_back({2'd0, 4'h7});
    exp_q.push_back({2'd1, 4'h3});
    exp_q.push_back({2'd2, 4'hA});
    exp_q.push_back({2'd3, 4'h4});
    start = 1'b1;
    @(posedge clk);
    for (int n = 1; n <= 24; n++) begin
      @(negedge clk);
      if (n == 1) start = 1'b0;
      if (busy) busy_n++;
      if (done) begin
        done_n++;
        done_at = n;
      end
    end
    checks++;
    if (done_at != 21 || done_n != 1) begin
      failures++;
      $display("FAIL seq_done_timing: got at=%0d count=%0d, required at=21 count=1", done_at, done_n);
    end
    checks++;
    if (busy_n != 20) begin
      failures++;
      $display("FAIL seq_busy_cycles: got %0d, required 20", busy_n);
    end
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL seq_write_count: got %0d writes missing, required 0", exp_q.size());
    end
    checks++;
    if ({tp_sel, t_val} !== {2'd3, 4'h4}) begin
      failures++;
      $display("FAIL seq_hold_idle: got sel=%0d val=%h, required sel=3 val=4", tp_sel, t_val);
    end
  endtask

  task automatic test_snapshot();
    int done_at;
    done_at = 0;
    cfg_vals = 16'h4A37;
    exp_q.push_back({2'd0, 4'h7});
    exp_q.push_back({2'd1, 4'h3});
    exp_q.push_back({2'd2, 4'hA});
    exp_q.push_back({2'd3, 4'h4});
    start = 1'b1;
    @(posedge clk);
    for (int n = 1; n <= 30; n++) begin
      @(negedge clk);
      if (n == 1) start = 1'b0;
      if (n == 3) cfg_vals = 16'hFFFF;
      if (done) done_at = n;
    end
    checks++;
    if (done_at != 21) begin
      failures++;
      $display("FAIL snap_done_timing: got %0d, required 21", done_at);
    end
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL snap_write_count: got %0d writes missing, required 0", exp_q.size());
    end
    checks++;
    if ({tp_sel, t_val, busy} !== {2'd3, 4'h4, 1'b0}) begin
      failures++;
      $display("FAIL snap_hold_idle: got sel=%0d val=%h busy=%b, required sel=3 val=4 busy=0",
               tp_sel, t_val, busy);
    end
    cfg_vals = 16'h4A37;
  endtask

  task automatic test_manual();
    int done_n;
    int done_at;
    int busy_n;
    done_n  = 0;
    done_at = 0;
    busy_n  = 0;
    man_sel = 2'd2;
    man_val = 4'h9;
    // two short glitches that must be filtered out
    for (int g = 0; g < 2; g++) begin
      @(negedge clk);
      man_btn = 1'b1;
      repeat (2) @(negedge clk);
      man_btn = 1'b0;
      for (int k = 0; k < 5; k++) begin
        @(negedge clk);
        if (busy) busy_n++;
      end
    end
    checks++;
    if (busy_n != 0) begin
      failures++;
      $display("FAIL man_glitch: got %0d busy cycles, required 0", busy_n);
    end
    exp_q.push_back({2'd2, 4'h9});
    man_btn = 1'b1;
    for (int n = 1; n <= 30; n++) begin
      @(negedge clk);
      if (n == 10) man_val = 4'hC;
      if (done) begin
        done_n++;
        done_at = n;
      end
    end
    checks++;
    if (done_at != 12 || done_n != 1) begin
      failures++;
      $display("FAIL man_done_timing: got at=%0d count=%0d, required at=12 count=1", done_at, done_n);
    end
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL man_write_count: got %0d writes missing, required 0", exp_q.size());
    end
    checks++;
    if ({tp_sel, t_val} !== {2'd2, 4'h9}) begin
      failures++;
      $display("FAIL man_hold_idle: got sel=%0d val=%h, required sel=2 val=9", tp_sel, t_val);
    end
    man_btn = 1'b0;
    busy_n  = 0;
    for (int k = 0; k < 15; k++) begin
      @(negedge clk);
      if (busy) busy_n++;
    end
    checks++;
    if (busy_n != 0) begin
      failures++;
      $display("FAIL man_release: got %0d busy cycles, required 0", busy_n);
    end
  endtask

  task automatic test_back_to_back();
    int done_n;
    int done_at;
    done_n  = 0;
    done_at = 0;
    cfg_vals = 16'h1E5B;
    man_sel  = 2'd1;
    man_val  = 4'h6;
    exp_q.push_back({2'd0, 4'hB});
    exp_q.push_back({2'd1, 4'h5});
    exp_q.push_back({2'd2, 4'hE});
    exp_q.push_back({2'd3, 4'h1});
    man_btn = 1'b1;
    for (int n = 1; n <= 40; n++) begin
      @(negedge clk);
      // debounced edge is present in cycle 6; start arrives in the same cycle
      if (n == 6 || n == 9 || n == 14 || n == 27) start = 1'b1;
      if (n == 7 || n == 10 || n == 15 || n == 28) start = 1'b0;
      if (done) begin
        done_n++;
        done_at = n;
      end
    end
    checks++;
    if (done_at != 27 || done_n != 1) begin
      failures++;
      $display("FAIL b2b_done_timing: got at=%0d count=%0d, required at=27 count=1", done_at, done_n);
    end
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL b2b_write_count: got %0d writes missing, required 0", exp_q.size());
    end
    man_btn = 1'b0;
    repeat (12) @(negedge clk);
  endtask

  task automatic test_reset_mid_pulse();
    int bad;
    int done_at;
    bad      = 0;
    done_at  = 0;
    cfg_vals = 16'h4A37;
    exp_q.push_back({2'd0, 4'h7});
    start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    checks++;
    if (reprogram !== 1'b1) begin
      failures++;
      $display("FAIL rst_pre_pulse: got rp=%b, required 1", reprogram);
    end
    #2 reset = 1'b0;
    #1;
    checks++;
    if ({reprogram, busy, done, tp_sel, t_val} !== 9'd0) begin
      failures++;
      $display("FAIL rst_abort: got rp=%b busy=%b done=%b sel=%0d val=%h, required all 0",
               reprogram, busy, done, tp_sel, t_val);
    end
    @(negedge clk);
    @(posedge clk);
    #2 reset = 1'b1;
    for (int k = 0; k < 15; k++) begin
      @(negedge clk);
      if (busy || reprogram || done) bad++;
    end
    checks++;
    if (bad != 0 || exp_q.size() != 0) begin
      failures++;
      $display("FAIL rst_no_resume: got %0d active cycles, %0d queued, required 0 0", bad, exp_q.size());
    end
    // a fresh start after release runs a complete sequence
    exp_q.push_back({2'd0, 4'h7});
    exp_q.push_back({2'd1, 4'h3});
    exp_q.push_back({2'd2, 4'hA});
    exp_q.push_back({2'd3, 4'h4});
    start = 1'b1;
    @(posedge clk);
    for (int n = 1; n <= 24; n++) begin
      @(negedge clk);
      if (n == 1) start = 1'b0;
      if (done) done_at = n;
    end
    checks++;
    if (done_at != 21 || exp_q.size() != 0) begin
      failures++;
      $display("FAIL rst_restart: got done at %0d, %0d queued, required 21 0", done_at, exp_q.size());
    end
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    test_reset();
    test_sequence();
    test_snapshot();
    test_manual();
    test_back_to_back();
    test_reset_mid_pulse();
    repeat (5) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/reprogram_writer.md
Name: reprogram_writer

Overview:
- Initiator side of the traffic-light controller's time-parameter programming interface (tp_sel, t_val, reprogram).
- Replays a 4-entry table of timing parameters, or one manually entered parameter from a raw push-button, as correctly framed write transactions.
- Sits between board switches/buttons and the controller; its outputs connect directly to the controller's tp_sel/t_val/reprogram inputs.

Parameters:
HOLD_CYCLES, 2, clock cycles reprogram is held high per write (>=1)
GAP_CYCLES, 2, clock cycles reprogram is held low after each write before the next setup (>=1)
DB_CYCLES, 4, consecutive synchronized-stable cycles required to accept a man_btn level change (>=1)

Ports:
clk  in  1  system clock, rising edge
reset  in  1  asynchronous, active-low reset (0 = reset)
start  in  1  sampled high in IDLE -> write all 4 table entries, tp_sel 0..3 in order
cfg_vals  in  16  table; entry k = cfg_vals[4k+3:4k]
man_btn  in  1  raw asynchronous push-button, active-high
man_sel  in  2  parameter index for a manual write
man_val  in  4  value for a manual write
tp_sel  out  2  parameter index to controller
t_val  out  4  parameter value to controller
reprogram  out  1  write strobe to controller
busy  out  1  high while a write or write sequence is in progress
done  out  1  one-cycle pulse when a sequence or manual write completes

Behaviour:
- Reset (reset=0, async): tp_sel=0, t_val=0, reprogram=0, busy=0, done=0; FSM to IDLE; index, counters, synchronizer and debounce state cleared.
- Reset asserted mid-transaction aborts immediately; reprogram drops in the same instant; nothing resumes after release.
- Button path: 2-flop synchronizer on man_btn, then debounce. Debounced level changes only after DB_CYCLES consecutive cycles with the synchronized value differing from the current debounced level. A rising edge of the debounced level = manual request (single-cycle internal event).
- FSM states:
  - IDLE
    - start=1: snapshot cfg_vals; idx=0; mode=SEQ; go to SETUP.
    - Otherwise, manual request: snapshot man_sel/man_val; mode=MAN; go to SETUP.
    - start and manual request in the same cycle: start wins; the manual request is dropped.
  - SETUP (1 cycle): tp_sel/t_val driven with the current entry; reprogram=0; busy=1.
  - PULSE (HOLD_CYCLES cycles): reprogram=1; tp_sel/t_val stable.
  - GAP (GAP_CYCLES cycles): reprogram=0; tp_sel/t_val stable.
    - Then MAN mode, or SEQ mode with idx=3 -> DONE.
    - Otherwise idx+1 -> SETUP.
  - DONE (1 cycle): done=1, busy=0 -> IDLE.
- busy is high in SETUP, PULSE and GAP only. start and manual requests arriving while busy or in DONE are ignored, not queued.
- tp_sel/t_val change only on entry to SETUP and otherwise hold their last written values, including in IDLE.
- Snapshot rule: changes to cfg_vals, man_sel or man_val after the start/request cycle do not affect the transaction in flight.
- Latency: start sampled at edge E0 -> SETUP at E1; reprogram high E2..E(1+HOLD).
  - Each write takes 1+HOLD_CYCLES+GAP_CYCLES cycles (5 with defaults).
  - Full sequence: done pulses 4*(1+HOLD+GAP)+1 cycles after E0 (21 with defaults).
  - Manual write: done pulses 1+HOLD+GAP+1 cycles after the request (6).
- idx is a 2-bit counter; it never wraps past 3 within a sequence.

Test Plan:
- Reset while PULSE (reprogram=1) -> reprogram, busy, tp_sel, t_val all 0 at once; stays IDLE after release until a new start.
- cfg_vals=16'h4A37, 1-cycle start -> four strobes, each 2 cycles wide and preceded by 1 setup cycle, with (tp_sel,t_val) = (0,7),(1,3),(2,A),(3,4); done pulses exactly 21 cycles after start; busy high for 20 cycles.
- Manual: man_sel=2, man_val=9, man_btn high with 2-cycle glitches, then held 10 cycles -> no write on glitches; exactly one write (2,9) after sync+DB_CYCLES; done pulse; holding the button causes no repeat.
- start and a debounced manual edge in the same IDLE cycle -> table sequence only, no manual write; start re-pulsed mid-sequence -> ignored, still exactly 4 writes.
- cfg_vals changed to 16'hFFFF during write 1 -> writes still use the snapshot 16'h4A37 values; after DONE, tp_sel=3 and t_val=4 hold in IDLE.
